mpu_writeback: RTL and testbench

MPU_WRITEBACK -- requirements
Module: mpu_writeback

---
 rtl/mpu_writeback.sv | 159 +++++++++++++++
 tb/tb_mpu_writeback.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_writeback.sv
// rtl/mpu_writeback.sv - M x N result collector buffer that drains row-major to memory.
// Fills out of order from the collector, then streams 36 words with valid/ready handshake.

package global_defs;
  localparam int M     = 6;
  localparam int N     = 6;
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);
endpackage

package mpu_data_types;
  typedef logic [31:0] float_sp;
endpackage

module mpu_writeback
  import global_defs::*;
  import mpu_data_types::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           collector_active_write_in,
  input  logic [MBITS:0] collector_i_in,
  input  logic [NBITS:0] collector_j_in,
  input  float_sp        collector_element_in,
  input  logic           collector_finished_in,
  output logic           mem_valid_out,
  input  logic           mem_ready_in,
  output logic [5:0]     mem_addr_out,
  output float_sp        mem_data_out,
  output logic           busy_out,
  output logic           done_out,
  output logic           error_out
);

  localparam int                CELLS    = M * N;
  localparam int                AW       = 6;
  localparam logic [AW-1:0]     LAST_IDX = AW'(CELLS - 1);
  localparam logic [MBITS:0]    M_L      = (MBITS + 1)'(M);
  localparam logic [NBITS:0]    N_L      = (NBITS + 1)'(N);
  localparam logic [AW-1:0]     N_A      = AW'(N);
  localparam logic [CELLS-1:0]  ONE_HOT0 = {{(CELLS - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_FILL,
    WB_DRAIN,
    WB_DONE
  } wb_state_t;

  wb_state_t        r_state;
  wb_state_t        w_state_nxt;
  logic [CELLS-1:0] r_valid;
  logic [CELLS-1:0] w_valid_nxt;
  logic [CELLS-1:0] w_wr_mask;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx_nxt;
  logic             r_error;
  logic             w_error_nxt;
  logic             w_in_range;
  logic             w_wr_en;
  logic             w_strobe;
  logic [AW-1:0]    w_wr_addr;
  float_sp          r_buf [CELLS];

  assign w_in_range = (collector_i_in < M_L) && (collector_j_in < N_L);
  assign w_wr_addr  = AW'(collector_i_in) * N_A + AW'(collector_j_in);
  assign w_wr_mask  = ONE_HOT0 << w_wr_addr;
  assign w_strobe   = collector_active_write_in || collector_finished_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_error_nxt = r_error;
    w_wr_en     = 1'b0;
    case (r_state)
      WB_IDLE, WB_FILL: begin
        if (collector_active_write_in) begin
          if (w_in_range) begin
            w_wr_en     = 1'b1;
            w_valid_nxt = r_valid | w_wr_mask;
            w_state_nxt = WB_FILL;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
        // Completeness includes a write landing in the same cycle as finished.
        if (collector_finished_in) begin
          if (&w_valid_nxt) begin
            w_state_nxt = WB_DRAIN;
            w_idx_nxt   = '0;
          end else begin
            w_error_nxt = 1'b1;
            w_valid_nxt = '0;
            w_state_nxt = WB_IDLE;
          end
        end
      end
      WB_DRAIN: begin
        if (w_strobe) begin
          w_error_nxt = 1'b1;
        end
        if (mem_ready_in) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = WB_DONE;
            w_valid_nxt = '0;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      WB_DONE: begin
        if (w_strobe) begin
          w_error_nxt = 1'b1;
        end
        w_state_nxt = WB_IDLE;
      end
      default: begin
        w_state_nxt = WB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_idx   <= '0;
      r_error <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_error <= w_error_nxt;
    end
  end

  // Data storage is qualified by r_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[w_wr_addr] <= collector_element_in;
    end
  end

  assign mem_valid_out = (r_state == WB_DRAIN);
  assign mem_addr_out  = mem_valid_out ? r_idx : '0;
  assign mem_data_out  = mem_valid_out ? r_buf[r_idx] : '0;
  assign busy_out      = (r_state != WB_IDLE);
  assign done_out      = (r_state == WB_DONE);
  assign error_out     = r_error;

endmodule

// File: tb/tb_mpu_writeback.sv
// tb/tb_mpu_writeback.sv - scoreboard bench for mpu_writeback.
// Expected drain words are queued at fill time and popped on each handshake.

module tb_mpu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        collector_active_write_in;
  logic [3:0]  collector_i_in;
  logic [3:0]  collector_j_in;
  logic [31:0] collector_element_in;
  logic        collector_finished_in;
  logic        mem_valid_out;
  logic        mem_ready_in;
  logic [5:0]  mem_addr_out;
  logic [31:0] mem_data_out;
  logic        busy_out;
  logic        done_out;
  logic        error_out;

  int errors = 0;
  int checks = 0;
  logic [37:0] sb_q[$];

  mpu_writeback dut (
    .clk                       (clk),
    .rst                       (rst),
    .collector_active_write_in (collector_active_write_in),
    .collector_i_in            (collector_i_in),
    .collector_j_in            (collector_j_in),
    .collector_element_in      (collector_element_in),
    .collector_finished_in     (collector_finished_in),
    .mem_valid_out             (mem_valid_out),
    .mem_ready_in              (mem_ready_in),
    .mem_addr_out              (mem_addr_out),
    .mem_data_out              (mem_data_out),
    .busy_out                  (busy_out),
    .done_out                  (done_out),
    .error_out                 (error_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i2f(input int k);
    int e;
    int m;
    if (k == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (k[b]) e = b;
    m = (k << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    collector_active_write_in = 1'b0;
    collector_finished_in = 1'b0;
    mem_ready_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill(input int skip, input bit fin_last, input bit push);
    for (int k = 0; k < 36; k++) begin
      if (k == skip) continue;
      @(negedge clk);
      collector_active_write_in = 1'b1;
      collector_i_in = 4'(k / 6);
      collector_j_in = 4'(k % 6);
      collector_element_in = i2f(k);
      collector_finished_in = fin_last && (k == 35);
      if (push) sb_q.push_back({6'(k), i2f(k)});
    end
    @(negedge clk);
    collector_active_write_in = 1'b0;
    collector_finished_in = 1'b0;
  endtask

  task automatic run_drain(input bit bp, input int poke_at, input int rst_at, input int exp_cycles);
    int cyc = 0;
    bit held = 0;
    bit aborted = 0;
    logic [37:0] hold_v;
    logic [37:0] exp_v;
    while (sb_q.size() > 0 && cyc < 400 && !aborted) begin
      mem_ready_in = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      collector_active_write_in = 1'b0;
      checks++;
      if (mem_valid_out !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid cyc=%0d got=%b exp=1", cyc, mem_valid_out);
      end
      if (held) begin
        checks++;
        if ({mem_addr_out, mem_data_out} !== hold_v) begin
          errors++;
          $display("FAIL hold_stable cyc=%0d got=%0h exp=%0h", cyc, {mem_addr_out, mem_data_out}, hold_v);
        end
      end
      if (int'(mem_addr_out) == poke_at) begin
        collector_active_write_in = 1'b1;
        collector_i_in = 4'd1;
        collector_j_in = 4'd5;
        collector_element_in = 32'hDEAD_BEEF;
      end
      if (int'(mem_addr_out) == rst_at) begin
        rst = 1'b1;
        aborted = 1;
      end else if (mem_ready_in) begin
        exp_v = sb_q.pop_front();
        checks++;
        if ({mem_addr_out, mem_data_out} !== exp_v) begin
          errors++;
          $display("FAIL drain_word got=%0h exp=%0h", {mem_addr_out, mem_data_out}, exp_v);
        end
        held = 0;
      end else begin
        held = 1;
        hold_v = {mem_addr_out, mem_data_out};
      end
      @(negedge clk);
      cyc++;
    end
    collector_active_write_in = 1'b0;
    if (aborted) begin
      rst = 1'b0;
      sb_q.delete();
      checks++;
      if ({mem_valid_out, busy_out, error_out} !== 3'b000) begin
        errors++;
        $display("FAIL rst_abort got=%b exp=000", {mem_valid_out, busy_out, error_out});
      end
      @(negedge clk);
      checks++;
      if ({mem_valid_out, done_out} !== 2'b00) begin
        errors++;
        $display("FAIL rst_no_done got=%b exp=00", {mem_valid_out, done_out});
      end
      mem_ready_in = 1'b0;
      return;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d left exp=0", sb_q.size());
      sb_q.delete();
    end
    if (exp_cycles > 0) begin
      checks++;
      if (cyc != exp_cycles) begin
        errors++;
        $display("FAIL throughput got=%0d exp=%0d", cyc, exp_cycles);
      end
    end
    mem_ready_in = 1'b0;
    checks++;
    if ({done_out, busy_out, mem_valid_out, mem_addr_out} !== {3'b110, 6'd0}) begin
      errors++;
      $display("FAIL done_pulse got=%b exp=110", {done_out, busy_out, mem_valid_out});
    end
    @(negedge clk);
    checks++;
    if ({done_out, busy_out} !== 2'b00) begin
      errors++;
      $display("FAIL after_done got=%b exp=00", {done_out, busy_out});
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({mem_valid_out, mem_addr_out, mem_data_out, busy_out, done_out, error_out} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%0h exp=0", {mem_valid_out, mem_addr_out, mem_data_out, busy_out, done_out, error_out});
    end
  endtask

  task automatic test_full_fill();
    fill(-1, 1'b1, 1'b1);
    run_drain(1'b0, -1, -1, 36);
    checks++;
    if (error_out !== 1'b0) begin
      errors++;
      $display("FAIL full_fill_error got=%b exp=0", error_out);
    end
  endtask

  task automatic test_backpressure();
    fill(-1, 1'b1, 1'b1);
    run_drain(1'b1, -1, -1, 0);
    checks++;
    if (error_out !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_error got=%b exp=0", error_out);
    end
  endtask

  task automatic test_incomplete();
    fill(22, 1'b0, 1'b0);
    collector_finished_in = 1'b1;
    @(negedge clk);
    collector_finished_in = 1'b0;
    checks++;
    if ({error_out, busy_out, mem_valid_out} !== 3'b100) begin
      errors++;
      $display("FAIL incomplete_state got=%b exp=100", {error_out, busy_out, mem_valid_out});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_valid_out !== 1'b0) begin
        errors++;
        $display("FAIL incomplete_no_valid got=%b exp=0", mem_valid_out);
      end
    end
    collector_active_write_in = 1'b1;
    collector_i_in = 4'd3;
    collector_j_in = 4'd4;
    collector_element_in = i2f(22);
    collector_finished_in = 1'b1;
    @(negedge clk);
    collector_active_write_in = 1'b0;
    collector_finished_in = 1'b0;
    checks++;
    if ({busy_out, mem_valid_out} !== 2'b00) begin
      errors++;
      $display("FAIL incomplete_valid_cleared got=%b exp=00", {busy_out, mem_valid_out});
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    collector_active_write_in = 1'b1;
    collector_i_in = 4'd6;
    collector_j_in = 4'd0;
    collector_element_in = 32'hBAD0_0001;
    @(negedge clk);
    collector_i_in = 4'd0;
    collector_j_in = 4'd6;
    @(negedge clk);
    collector_active_write_in = 1'b0;
    checks++;
    if ({error_out, mem_valid_out} !== 2'b10) begin
      errors++;
      $display("FAIL oor_error got=%b exp=10", {error_out, mem_valid_out});
    end
    fill(6, 1'b1, 1'b0);
    checks++;
    if ({busy_out, mem_valid_out} !== 2'b00) begin
      errors++;
      $display("FAIL oor_no_valid_bit got=%b exp=00", {busy_out, mem_valid_out});
    end
    collector_active_write_in = 1'b1;
    collector_i_in = 4'd1;
    collector_j_in = 4'd1;
    collector_element_in = 32'h1234_5678;
    fill(-1, 1'b1, 1'b1);
    run_drain(1'b0, -1, -1, 36);
  endtask

  task automatic test_write_during_drain();
    apply_reset();
    fill(-1, 1'b1, 1'b1);
    run_drain(1'b0, 10, -1, 36);
    checks++;
    if (error_out !== 1'b1) begin
      errors++;
      $display("FAIL drain_write_error got=%b exp=1", error_out);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    fill(-1, 1'b1, 1'b1);
    run_drain(1'b0, -1, 20, 0);
    fill(-1, 1'b1, 1'b1);
    run_drain(1'b0, -1, -1, 36);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    collector_active_write_in = 1'b0;
    collector_i_in = '0;
    collector_j_in = '0;
    collector_element_in = '0;
    collector_finished_in = 1'b0;
    mem_ready_in = 1'b0;
    test_reset();
    test_full_fill();
    test_backpressure();
    test_incomplete();
    test_out_of_range();
    test_write_during_drain();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
